pulse_sync_multi: RTL and testbench
===================================

Name: pulse_sync_multi

Overview:
- Multi-channel asynchronous-event receiver. It brings pCHANNELS independent asynchronous level or toggle inputs into the single `clk` domain.
- Per channel it detects the selected edge type and queues events in a saturating counter. Queued events are presented downstream as valid/ready one-event-per-transfer pulses.
- Generalises the two-clock single-pulse synchroniser: configurable chain depth, channel count and edge mode, plus lossless event queuing and sticky overflow reporting.
- Sits at the boundary where foreign-domain strobes, already converted to levels or toggles, enter the `clk` domain.

Parameters:
- pCHANNELS, 4: number of independent channels, ≥1.
- pLENGTH, 3: synchroniser flops per channel, ≥2.
- pEDGE, 2: event edge. 0 = rising, 1 = falling, 2 = both (toggle mode).
- pCNT_W, 3: pending-event counter width. Saturates at 2^pCNT_W−1.
- pFILT, 2: glitch-filter stability cycles, ≥1. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- async_in  in  pCHANNELS  asynchronous inputs, one per channel.
- sout_valid  out  pCHANNELS  channel has ≥1 pending event.
- sout_ready  in  pCHANNELS  downstream accepts one event this cycle.
- overflow  out  pCHANNELS  sticky: an event was lost to saturation.
- clr_ovf  in  pCHANNELS  synchronous clear of overflow, per channel.
- any_pending  out  1  OR of all sout_valid.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all sync flops, the edge-history flop, counters and overflow go to 0.
  - sout_valid, overflow and any_pending read 0 while reset is asserted.
- Synchroniser: per channel, a pLENGTH-deep shift chain samples async_in. s = last stage. An extra history flop h holds the previous s.
- Event detection, combinational on s and h:
  - pEDGE=0: s & ~h.
  - pEDGE=1: ~s & h.
  - pEDGE=2: s ^ h.
- Latency: an input change first sampled at edge k sets s at edge k+pLENGTH−1. The counter increments at edge k+pLENGTH, so sout_valid is high after edge k+pLENGTH.
- Transfer: occurs when sout_valid & sout_ready in the same cycle. Each transfer consumes exactly one event.
- Output logic: sout_valid = (cnt≠0), driven directly from the registered count. There is no combinational path from sout_ready to sout_valid.
- Counter update per cycle:
  - event & ~xfer: cnt+1 if cnt < max; otherwise cnt holds and overflow sets.
  - ~event & xfer: cnt−1.
  - event & xfer: cnt unchanged. This holds even at max, and overflow is not set.
  - neither: hold.
- Overflow is sticky. clr_ovf clears it on the next edge. If a set and clr_ovf occur in the same cycle, set wins.
- Channels are fully independent. There is no arbitration and no cross-channel coupling.
- Input constraint: the input must hold each level for ≥2 clk cycles for every edge to be counted. Shorter pulses may be lost; this is not flagged.
- Reset mid-operation: pending events are discarded. After release, h and s restart from 0. With pEDGE=0 or 2, an input held high across reset produces one event after release. This is required behaviour.

Optional Feature:
- Macro: PULSE_SYNC_MULTI_FILTER_EN.
- Defined:
  - a per-channel filter sits between s and h.
  - s must remain at a new value for pFILT consecutive cycles before the filtered value f updates. Edge detection then uses f versus h.
  - the filter counter resets to 0 on reset_n and whenever s changes back before qualifying.
  - added latency is pFILT cycles.
  - shorter glitches produce no event.
- Undefined: no filter logic is built. Detection uses s directly. Latency is as stated above.

Test Plan:
- Basic rising edge: pEDGE=0, pLENGTH=3, ch0 rises and holds. Require sout_valid[0]=1 exactly 3 edges after first sampling. One transfer with ready=1 returns it to 0. Other channels stay 0.
- Toggle mode: pEDGE=2, ch1 toggles 5 times at 4-cycle spacing with sout_ready=0. Require cnt reaches 5 and sout_valid[1]=1. Then ready=1 for 5 cycles. Require exactly 5 transfers, after which sout_valid[1]=0 and overflow[1]=0.
- Saturation: pCNT_W=3, ready=0, 9 toggles on ch2 (pEDGE=2). Require cnt holds at 7 and overflow[2]=1. A clr_ovf[2] pulse clears it. Clear in the same cycle as a 10th lost event: overflow stays 1.
- Simultaneous event and transfer: cnt=7 with ready=1 on the event cycle. Require cnt stays 7 and overflow stays 0.
- Reset mid-operation: 3 events pending on ch3, reset_n pulsed low asynchronously mid-cycle. Require sout_valid, overflow and any_pending = 0 immediately. With the input held high and pEDGE=0, exactly 1 event appears after release.
- Filter, with PULSE_SYNC_MULTI_FILTER_EN and pFILT=2:
  - a 1-cycle high glitch on ch0 gives no event.
  - a 4-cycle high gives exactly 1 event, with valid at pLENGTH+pFILT edges after first sampling.

Source files
------------

// File: rtl/pulse_sync_multi.sv
// Multi-channel async event receiver: per-channel synchroniser, edge detector and
// saturating event queue with valid/ready output. Optional glitch filter: PULSE_SYNC_MULTI_FILTER_EN.
module pulse_sync_multi #(
    parameter int pCHANNELS = 4,
    parameter int pLENGTH   = 3,
    parameter int pEDGE     = 2,
    parameter int pCNT_W    = 3,
    parameter int pFILT     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [pCHANNELS-1:0] async_in,
    output logic [pCHANNELS-1:0] sout_valid,
    input  logic [pCHANNELS-1:0] sout_ready,
    output logic [pCHANNELS-1:0] overflow,
    input  logic [pCHANNELS-1:0] clr_ovf,
    output logic                 any_pending
);

    localparam logic [pCNT_W-1:0] CNT_MAX = '1;

    if (pCHANNELS < 1 || pLENGTH < 2 || pEDGE < 0 || pEDGE > 2 || pCNT_W < 1 || pFILT < 1)
    begin : g_bad_params
        $error("pulse_sync_multi: illegal parameter value");
    end

    logic [pCHANNELS-1:0][pLENGTH-1:0] sync_p0;
    logic [pCHANNELS-1:0]              s_p0;
    logic [pCHANNELS-1:0]              det_p1;
    logic [pCHANNELS-1:0]              hist_p1;
    logic [pCHANNELS-1:0][pCNT_W-1:0]  cnt_p2;
    logic [pCHANNELS-1:0]              ovf_p2;
    logic [pCHANNELS-1:0]              event_w;
    logic [pCHANNELS-1:0]              xfer_w;
    logic [pCHANNELS-1:0]              ovf_set_w;

    function automatic logic edge_hit(input logic cur, input logic prev);
        case (pEDGE)
            0:       edge_hit = cur & ~prev;
            1:       edge_hit = ~cur & prev;
            default: edge_hit = cur ^ prev;
        endcase
    endfunction

    // Saturating queue step; a simultaneous event and transfer leaves the count unchanged.
    function automatic logic [pCNT_W-1:0] cnt_step(input logic [pCNT_W-1:0] cnt,
                                                   input logic ev, input logic xf);
        cnt_step = cnt;
        if (ev && !xf && cnt != CNT_MAX)
            cnt_step = cnt + 1'b1;
        else if (!ev && xf)
            cnt_step = cnt - 1'b1;
    endfunction

    // Stage 0: synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
        end else begin
            for (int c = 0; c < pCHANNELS; c++)
                sync_p0[c] <= {sync_p0[c][pLENGTH-2:0], async_in[c]};
        end
    end

    always_comb begin
        s_p0 = '0;
        for (int c = 0; c < pCHANNELS; c++)
            s_p0[c] = sync_p0[c][pLENGTH-1];
    end

    // Stage 1: optional stability filter, then edge history
`ifdef PULSE_SYNC_MULTI_FILTER_EN
    localparam int FCNT_W = $clog2(pFILT + 1);
    logic [pCHANNELS-1:0]              filt_p1;
    logic [pCHANNELS-1:0][FCNT_W-1:0]  fcnt_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_p1 <= '0;
            fcnt_p1 <= '0;
        end else begin
            for (int c = 0; c < pCHANNELS; c++) begin
                if (s_p0[c] == filt_p1[c]) begin
                    fcnt_p1[c] <= '0;
                end else if (fcnt_p1[c] == FCNT_W'(pFILT - 1)) begin
                    filt_p1[c] <= s_p0[c];
                    fcnt_p1[c] <= '0;
                end else begin
                    fcnt_p1[c] <= fcnt_p1[c] + 1'b1;
                end
            end
        end
    end

    assign det_p1 = filt_p1;
`else
    assign det_p1 = s_p0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hist_p1 <= '0;
        else
            hist_p1 <= det_p1;
    end

    always_comb begin
        event_w   = '0;
        xfer_w    = '0;
        ovf_set_w = '0;
        for (int c = 0; c < pCHANNELS; c++) begin
            event_w[c]   = edge_hit(det_p1[c], hist_p1[c]);
            xfer_w[c]    = sout_valid[c] & sout_ready[c];
            ovf_set_w[c] = event_w[c] & ~xfer_w[c] & (cnt_p2[c] == CNT_MAX);
        end
    end

    // Stage 2: event queue and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p2 <= '0;
            ovf_p2 <= '0;
        end else begin
            for (int c = 0; c < pCHANNELS; c++) begin
                cnt_p2[c] <= cnt_step(cnt_p2[c], event_w[c], xfer_w[c]);
                ovf_p2[c] <= ovf_set_w[c] | (ovf_p2[c] & ~clr_ovf[c]);
            end
        end
    end

    always_comb begin
        sout_valid = '0;
        for (int c = 0; c < pCHANNELS; c++)
            sout_valid[c] = |cnt_p2[c];
    end

    assign overflow    = ovf_p2;
    assign any_pending = |sout_valid;

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Bench for pulse_sync_multi: a toggle-mode instance and a rising-edge instance checked
// every cycle against a delay-line reference model, plus directed and table-driven sequences.
module tb_pulse_sync_multi;

    localparam int CH   = 4;
    localparam int LEN  = 3;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [CH-1:0] async_t = '0, ready_t = '0, clr_t = '0, valid_t, ovf_t;
    logic [CH-1:0] async_r = '0, ready_r = '0, clr_r = '0, valid_r, ovf_r;
    logic          anyp_t, anyp_r;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulse_sync_multi #(.pCHANNELS(CH), .pLENGTH(LEN), .pEDGE(2), .pCNT_W(CW), .pFILT(2)) dut_t (
        .clk(clk), .reset_n(reset_n), .async_in(async_t), .sout_valid(valid_t),
        .sout_ready(ready_t), .overflow(ovf_t), .clr_ovf(clr_t), .any_pending(anyp_t));

    pulse_sync_multi #(.pCHANNELS(CH), .pLENGTH(LEN), .pEDGE(0), .pCNT_W(CW), .pFILT(2)) dut_r (
        .clk(clk), .reset_n(reset_n), .async_in(async_r), .sout_valid(valid_r),
        .sout_ready(ready_r), .overflow(ovf_r), .clr_ovf(clr_r), .any_pending(anyp_r));

    // Reference model: the detector sees the input as sampled LEN edges earlier,
    // compared with the sample one edge before that.
    bit dl   [2][CH][LEN+1];
    int mcnt [2][CH];
    bit movf [2][CH];

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                for (int i = 0; i <= LEN; i++) dl[d][c][i] = 1'b0;
                mcnt[d][c] = 0;
                movf[d][c] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                bit inb, rdy, clr, s, h, ev, xf, set;
                inb = (d == 0) ? async_t[c] : async_r[c];
                rdy = (d == 0) ? ready_t[c] : ready_r[c];
                clr = (d == 0) ? clr_t[c]   : clr_r[c];
                s   = dl[d][c][1];
                h   = dl[d][c][0];
                ev  = (d == 0) ? (s != h) : (s && !h);
                xf  = (mcnt[d][c] > 0) && rdy;
                set = 1'b0;
                if (ev && !xf) begin
                    if (mcnt[d][c] < MAXC) mcnt[d][c]++;
                    else set = 1'b1;
                end else if (!ev && xf) begin
                    mcnt[d][c]--;
                end
                if (set) movf[d][c] = 1'b1;
                else if (clr) movf[d][c] = 1'b0;
                for (int i = 0; i < LEN; i++) dl[d][c][i] = dl[d][c][i+1];
                dl[d][c][LEN] = inb;
            end
    endtask

    task automatic compare_model();
        logic [CH-1:0] ev_t, eo_t, ev_r, eo_r;
        for (int c = 0; c < CH; c++) begin
            ev_t[c] = (mcnt[0][c] != 0);
            eo_t[c] = movf[0][c];
            ev_r[c] = (mcnt[1][c] != 0);
            eo_r[c] = movf[1][c];
        end
        chk("model_valid_t", valid_t, ev_t);
        chk("model_ovf_t",   ovf_t,   eo_t);
        chk("model_any_t",   anyp_t,  |ev_t);
        chk("model_valid_r", valid_r, ev_r);
        chk("model_ovf_r",   ovf_r,   eo_r);
        chk("model_any_r",   anyp_r,  |ev_r);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        compare_model();
    endtask

    task automatic reset_pulse();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid_t", valid_t, 0);
        chk("rst_ovf_t",   ovf_t,   0);
        chk("rst_any_t",   anyp_t,  0);
        chk("rst_valid_r", valid_r, 0);
        chk("rst_ovf_r",   ovf_r,   0);
        chk("rst_any_r",   anyp_r,  0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit tog;
        bit rdy;
        bit clr;
        bit exp_v;
        bit exp_o;
    } vec_t;

    vec_t tbl[13];
    int   xf;
    int   hold [2][CH];

    initial begin
        // Channel 2 of the toggle instance, starting saturated (count 7, overflow set)
        tbl[0]  = '{0, 0, 1, 1, 0};
        tbl[1]  = '{1, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 1, 1};
        tbl[5]  = '{0, 1, 0, 1, 1};
        tbl[6]  = '{0, 1, 1, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_valid_t", valid_t, 0);
        chk("init_ovf_t",   ovf_t,   0);
        chk("init_any_t",   anyp_t,  0);
        chk("init_valid_r", valid_r, 0);
        chk("init_any_r",   anyp_r,  0);
        reset_n = 1'b1;
        step();

        // Rising edge on the rising-mode instance: valid LEN edges after first sampling
        async_r[0] = 1'b1;
        for (int i = 1; i <= LEN + 1; i++) begin
            step();
            chk("rise_latency", valid_r[0], (i == LEN + 1) ? 1 : 0);
        end
        chk("rise_other_ch", valid_r[3:1], 0);
        ready_r[0] = 1'b1;
        step();
        ready_r[0] = 1'b0;
        chk("rise_drained", valid_r[0], 0);

        // Toggle mode: 5 toggles queued, then 5 transfers
        for (int t = 0; t < 5; t++) begin
            async_t[1] = ~async_t[1];
            repeat (4) step();
        end
        chk("tog_valid", valid_t[1], 1);
        ready_t[1] = 1'b1;
        xf = 0;
        repeat (6) begin
            if (valid_t[1]) xf++;
            step();
        end
        ready_t[1] = 1'b0;
        chk("tog_xfers", xf, 5);
        chk("tog_valid_end", valid_t[1], 0);
        chk("tog_ovf", ovf_t[1], 0);

        // Saturation: 9 toggles with no ready
        repeat (9) begin
            async_t[2] = ~async_t[2];
            repeat (3) step();
        end
        repeat (LEN + 1) step();
        chk("sat_valid", valid_t[2], 1);
        chk("sat_ovf", ovf_t[2], 1);
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].tog) async_t[2] = ~async_t[2];
            ready_t[2] = tbl[i].rdy;
            clr_t[2]   = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_valid", i), valid_t[2], tbl[i].exp_v);
            chk($sformatf("tbl%0d_ovf", i),   ovf_t[2],   tbl[i].exp_o);
        end
        ready_t[2] = 1'b0;
        clr_t[2]   = 1'b0;

        // Event and transfer together at full count: count holds, no overflow
        repeat (7) begin
            async_t[0] = ~async_t[0];
            repeat (3) step();
        end
        async_t[0] = ~async_t[0];
        repeat (LEN) step();
        ready_t[0] = 1'b1;
        step();
        ready_t[0] = 1'b0;
        chk("max_evxf_ovf", ovf_t[0], 0);
        chk("max_evxf_valid", valid_t[0], 1);
        ready_t[0] = 1'b1;
        xf = 0;
        repeat (9) begin
            if (valid_t[0]) xf++;
            step();
        end
        ready_t[0] = 1'b0;
        chk("max_evxf_drain", xf, 7);

        // Reset mid-operation: 3 rising events pending on ch3, input left high
        repeat (2) begin
            async_r[3] = 1'b1;
            repeat (3) step();
            async_r[3] = 1'b0;
            repeat (3) step();
        end
        async_r[3] = 1'b1;
        repeat (LEN + 2) step();
        chk("rst_pending", valid_r[3], 1);
        reset_pulse();
        repeat (LEN + 2) step();
        chk("rst_held_high", valid_r[3], 1);
        ready_r[3] = 1'b1;
        xf = 0;
        repeat (4) begin
            if (valid_r[3]) xf++;
            step();
        end
        ready_r[3] = 1'b0;
        chk("rst_one_event", xf, 1);

        // Randomized traffic, all outputs checked against the model each cycle
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) hold[d][c] = $urandom_range(1, 5);
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[0][c] == 0) begin
                    async_t[c] = ~async_t[c];
                    hold[0][c] = $urandom_range(2, 6);
                end else hold[0][c]--;
                if (hold[1][c] == 0) begin
                    async_r[c] = ~async_r[c];
                    hold[1][c] = $urandom_range(2, 6);
                end else hold[1][c]--;
                ready_t[c] = (n < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
                ready_r[c] = (n < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
                clr_t[c]   = ($urandom_range(0, 15) == 0);
                clr_r[c]   = ($urandom_range(0, 15) == 0);
            end
            if (n == 400) reset_pulse();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
